mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with HI/LO registers.
- Sits directly downstream of the register file: consumes its two read-port operands (rs on data1, rt on data2) for MULT/MULTU/DIV/DIVU.
- Also takes MTHI/MTLO writes, and drives HI/LO to the MFHI/MFLO writeback path.
- Radix-2: one partial-product or quotient bit per clock. The pipeline stalls on busy.

Parameters:
- WIDTH, 32: operand and HI/LO width. Only 32 is verified.
- CNT_W, 5: iteration counter width. Must satisfy 2^CNT_W = WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request an operation; sampled only in IDLE
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_data  in  WIDTH  multiplicand/dividend (register file data1)
- rt_data  in  WIDTH  multiplier/divisor (register file data2)
- hi_we  in  1  MTHI write enable
- lo_we  in  1  MTLO write enable
- wrdata  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO have been updated by an op
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal operand registers cleared.
  - Reset asserted mid-operation aborts the op with no HI/LO update.
  - Operation resumes only on a new start after release.
- State machine: IDLE -> RUN -> IDLE.
- IDLE, rising edge with start=1:
  - latch op, sign flags, and operand magnitudes. For signed ops, negative operands are two's-complement negated.
  - counter=0, busy=1 from the next cycle, state=RUN.
- RUN: each edge performs one iteration and increments counter.
  - Multiply: shift-add over the 2*WIDTH product.
  - Divide: restoring shift-subtract over the WIDTH-bit remainder.
- Commit edge: on the edge where counter==WIDTH-1 (the 32nd RUN edge, i.e. 32 edges after the start edge):
  - hi/lo are written with the sign-corrected result.
  - state=IDLE, busy=0.
  - done=1 for exactly the following cycle.
- Sign correction:
  - MULT: product negated if sign(rs) XOR sign(rt).
  - DIV: quotient negated if signs differ; remainder takes the sign of the dividend.
- Result placement:
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0].
  - Divide: lo=quotient, hi=remainder.
- Divide by zero (DIV or DIVU): full 32-cycle latency; lo=all ones, hi=original rs_data (unnegated).
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: ignored. Operands on the bus during RUN are don't-care, because operands are latched at the start edge.
- hi_we/lo_we:
  - In IDLE: write wrdata into hi/lo on the edge. Both may be asserted together.
  - In RUN: ignored; the hazard unit guarantees none are issued.
- start and hi_we/lo_we in the same IDLE edge: the MTHI/MTLO write takes effect and the op starts. The later commit overwrites both registers.
- hi/lo change only on a commit edge, an IDLE MTHI/MTLO edge, or reset. They hold their value throughout RUN.
- No combinational path from any input to any output.

Test Plan:
- Reset, then hold: rst_n=0 for 12 ns, release -> hi=0, lo=0, busy=0, done=0; idle 50 cycles with no change.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF ->
  - busy high for 32 cycles;
  - then hi=0xFFFFFFFE, lo=0x00000001;
  - done pulses for exactly 1 cycle, 33 cycles after the start edge.
- MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
- DIVU 100 / 0 -> after 32 cycles lo=0xFFFFFFFF, hi=100.
- MTHI 0x1234 and MTLO 0x5678 in IDLE -> hi=0x1234, lo=0x5678 next cycle. Then:
  - start DIVU 10/3;
  - pulse start (DIVU 9/9) and hi_we mid-RUN -> both ignored; final lo=3, hi=1.
- Start MULTU 5 x 5, assert rst_n=0 at cycle 10 of RUN -> hi/lo=0 immediately, busy=0; no done pulse after release.

Source files
------------

// File: rtl/mdu_hilo.sv
// mdu_hilo -- iterative radix-2 multiply/divide unit with HI/LO registers.
//
// An operation is requested with start while idle. The operands are latched
// as magnitudes at that edge. The unit then runs one shift-add (multiply) or
// restoring shift-subtract (divide) step per clock for WIDTH clocks. On the
// last step it writes the sign-corrected result into HI/LO.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request an operation (sampled only in IDLE)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data  multiplicand / dividend
//   rt_data  multiplier / divisor
//   hi_we    MTHI write enable (IDLE only)
//   lo_we    MTLO write enable (IDLE only)
//   wrdata   MTHI/MTLO data
//   busy     operation in progress
//   done     one-cycle pulse after the edge that committed a result
//   hi, lo   HI and LO registers
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wrdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_res;    // product/quotient must be negated
    logic               neg_rem;    // remainder takes the dividend's sign
    logic               div_zero;
    logic [2*WIDTH-1:0] acc;        // multiply: {partial, multiplier}; divide: {remainder, quotient}
    logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
    logic               last;

    // Operand decode at the start edge
    logic               op_signed;
    logic               rs_neg, rt_neg;
    logic [WIDTH-1:0]   rs_mag, rt_mag;

    // One iteration and the final sign-corrected result
    logic [WIDTH:0]     add_sum, shifted, trial;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;
    logic [WIDTH-1:0]   hi_res, lo_res;

    assign busy = (state == RUN);
    assign last = (state == RUN) && (cnt == CNT_W'(WIDTH - 1));

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        op_signed = ~op[0];
        rs_neg    = op_signed & rs_data[WIDTH-1];
        rt_neg    = op_signed & rt_data[WIDTH-1];
        rs_mag    = rs_neg ? -rs_data : rs_data;
        rt_mag    = rt_neg ? -rt_data : rt_data;
    end

    always_comb begin
        // Multiply: add the multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift the whole product right.
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: bring the next dividend bit into the remainder. The partial
        // remainder is always below the divisor, so a non-negative trial
        // result fits in WIDTH bits and trial[WIDTH] acts as the borrow.
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        trial   = shifted - {1'b0, opnd};
        if (is_div) begin
            if (!trial[WIDTH]) step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else               step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end else begin
            step = {add_sum, acc[WIDTH-1:1]};
        end

        prod_s = neg_res ? -step : step;
        quot_s = neg_res ? -step[WIDTH-1:0] : step[WIDTH-1:0];
        rem_s  = neg_rem ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];

        if (is_div) begin
            // With a zero divisor every trial subtraction succeeds. The
            // remainder therefore ends up as the dividend magnitude, and
            // re-applying the dividend sign restores the original rs value.
            lo_res = div_zero ? '1 : quot_s;
            hi_res = rem_s;
        end else begin
            lo_res = prod_s[WIDTH-1:0];
            hi_res = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Datapath and HI/LO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            acc      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= last;
            if (state == IDLE) begin
                if (hi_we) hi <= wrdata;
                if (lo_we) lo <= wrdata;
                if (start) begin
                    cnt      <= '0;
                    is_div   <= op[1];
                    neg_res  <= rs_neg ^ rt_neg;
                    neg_rem  <= rs_neg;
                    div_zero <= op[1] && (rt_data == '0);
                    if (op[1]) begin
                        acc  <= {{WIDTH{1'b0}}, rs_mag};
                        opnd <= rt_mag;
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, rt_mag};
                        opnd <= rs_mag;
                    end
                end
            end else begin
                acc <= step;
                cnt <= cnt + 1'b1;
                if (last) begin
                    hi <= hi_res;
                    lo <= lo_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Testbench for mdu_hilo: directed cases plus randomized operations checked
// against an arithmetic reference model.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wrdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;

    mdu_hilo #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hi_we(hi_we), .lo_we(lo_we), .wrdata(wrdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (o)
            2'b00: return 64'(sa * sb);
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Issue one op, check busy length, HI/LO hold during RUN, done pulse and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        logic [63:0] held;
        int edges;
        exp = model(o, a, b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; rs_data = $urandom; rt_data = $urandom;
        held = {hi, lo};
        edges = 0;
        while (busy && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (busy) chk({tag, " hold"}, {hi, lo}, held);
        end
        chk({tag, " busy_len"}, 64'(edges), 64'd32);
        chk({tag, " done"}, {63'b0, done}, 64'd1);
        chk({tag, " hilo"}, {hi, lo}, exp);
        $display("[TB] %s op=%0d rs=%h rt=%h -> hi=%h lo=%h", tag, o, a, b, hi, lo);
        @(posedge clk); #1;
        chk({tag, " done_clr"}, {63'b0, done}, 64'd0);
    endtask

    initial begin
        int edges;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        // Reset and idle hold
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset", {busy, done, hi, lo}, 66'd0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (i % 10 == 9) chk("idle", {busy, done, hi, lo}, 66'd0);
        end

        // Directed operations
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(2'b11, 32'd100, 32'd0, "divu_zero");
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0, "div_zero_neg");

        // MTHI/MTLO
        @(negedge clk);
        hi_we = 1'b1; lo_we = 1'b0; wrdata = 32'h1234;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; wrdata = 32'h5678;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});
        $display("[TB] mthi/mtlo hi=%h lo=%h", hi, lo);

        // DIVU 10/3 with start and hi_we pulsed mid-run
        start = 1'b1; op = 2'b11; rs_data = 32'd10; rt_data = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs_data = 32'd9; rt_data = 32'd9;
        hi_we = 1'b1; wrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("run_we_ignored", {hi, lo}, {32'h1234, 32'h5678});
        edges = 0;
        while (busy && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("run_busy_end", {63'b0, busy}, 64'd0);
        chk("run_divu", {hi, lo}, {32'd1, 32'd3});
        @(posedge clk); #1;
        chk("run_no_restart", {63'b0, busy}, 64'd0);
        $display("[TB] divu 10/3 with mid-run pulses hi=%h lo=%h", hi, lo);

        // MTHI together with start in the same IDLE edge
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'd2; rt_data = 32'd3;
        hi_we = 1'b1; wrdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        chk("we_and_start", {hi, 31'b0, busy}, {32'hCAFE_0001, 32'd1});
        edges = 0;
        while (busy && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("we_and_start_res", {hi, lo}, {32'd0, 32'd6});
        $display("[TB] mthi+start hi=%h lo=%h", hi, lo);

        // Randomized operations
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op(ro, ra, rb, "rand");
        end

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; rs_data = 32'd5; rt_data = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) edges++;
        end
        chk("abort_quiet", 64'(edges), 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        $display("[TB] reset mid-run hi=%h lo=%h busy=%0d", hi, lo, busy);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
